// File: rtl/osd_overlay_attr_pkg.sv
// Shared types and constants for the attribute-aware OSD overlay: timer states, palette, count sizing.
// No datapath here; latency and backpressure are defined by the modules that import it.
package osd_pkg;

    typedef enum logic [1:0] {OFF, SHOW, FORCED} osd_state_e;

    // RGB444 palette, index 0 in the low 12 bits
    localparam logic [15:0][11:0] PALETTE = {
        12'hFFF, 12'hFF5, 12'hF5F, 12'hF55,
        12'h5FF, 12'h5F5, 12'h55F, 12'h555,
        12'hAAA, 12'hA50, 12'hA0A, 12'hA00,
        12'h0AA, 12'h0A0, 12'h00A, 12'h000
    };

    function automatic int cnt_width(input int frames);
        return (frames < 1) ? 1 : $clog2(frames + 1);
    endfunction

endpackage

// File: rtl/osd_overlay_attr_timer.sv
// Frame-timed OSD visibility: trigger/force FSM, counted in vblank rising edges.
// osd_shown registers only on a frame tick; no backpressure (free-running video timing).
module osd_frame_timer
    import osd_pkg::*;
#(
    parameter int TIMEOUT_FRAMES = 120
) (
    input  logic clk,
    input  logic reset_n,
    input  logic vblank,
    input  logic osd_trigger,
    input  logic osd_force,
    output logic osd_shown
);

    localparam int CW = cnt_width(TIMEOUT_FRAMES);
    localparam logic [CW-1:0] RELOAD = CW'(TIMEOUT_FRAMES);

    osd_state_e    state, state_nxt;
    logic [CW-1:0] count, count_nxt;
    logic          vblank_q;
    logic          tick;

    assign tick = vblank & ~vblank_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= OFF;
            count     <= '0;
            vblank_q  <= 1'b1;
            osd_shown <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            vblank_q <= vblank;
            // Visibility only moves at the frame boundary so a frame is never torn
            if (tick) begin
                osd_shown <= (state_nxt != OFF);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        if (osd_force) begin
            state_nxt = FORCED;
        end else begin
            case (state)
                OFF: begin
                    if (osd_trigger && (TIMEOUT_FRAMES != 0)) begin
                        state_nxt = SHOW;
                        count_nxt = RELOAD;
                    end
                end
                SHOW: begin
                    if (osd_trigger) begin
                        count_nxt = RELOAD;
                    end else if (tick) begin
                        if (count == '0) begin
                            state_nxt = OFF;
                        end else begin
                            count_nxt = count - CW'(1);
                        end
                    end
                end
                FORCED: begin
                    state_nxt = SHOW;
                    count_nxt = RELOAD;
                end
                default: state_nxt = OFF;
            endcase
        end
    end

endmodule

// File: rtl/osd_overlay_attr.sv
// Attribute-coloured OSD text overlay composited over video in a fixed window.
// Latency 6 clocks input to rgb_out with matched blanking; no backpressure (pixel stream).
module osd_overlay_attr
    import osd_pkg::*;
#(
    parameter int CHAR_WIDTH     = 8,
    parameter int CHAR_HEIGHT    = 8,
    parameter int SCREEN_COLS    = 48,
    parameter int SCREEN_ROWS    = 32,
    parameter int X0             = 0,
    parameter int Y0             = 0,
    parameter int COLOR_W        = 8,
    parameter int TIMEOUT_FRAMES = 120
) (
    input  logic                                         clk,
    input  logic                                         reset_n,
    input  logic                                         hblank,
    input  logic                                         vblank,
    input  logic [9:0]                                   x,
    input  logic [9:0]                                   y,
    input  logic [3*COLOR_W-1:0]                         rgb_in,
    input  logic                                         osd_trigger,
    input  logic                                         osd_force,
    output logic [$clog2(SCREEN_COLS*SCREEN_ROWS)-1:0]   addr_b,
    input  logic [7:0]                                   char_code,
    input  logic [7:0]                                   char_attr,
    output logic [8+$clog2(CHAR_HEIGHT)-1:0]             font_addr,
    input  logic [CHAR_WIDTH-1:0]                        font_data,
    output logic [3*COLOR_W-1:0]                         rgb_out,
    output logic                                         hblank_out,
    output logic                                         vblank_out,
    output logic                                         osd_shown
);

    localparam int AW    = $clog2(SCREEN_COLS*SCREEN_ROWS);
    localparam int CWB   = $clog2(CHAR_WIDTH);
    localparam int CHB   = $clog2(CHAR_HEIGHT);
    localparam int FAW   = 8 + CHB;
    localparam int CXW   = (CWB > 0) ? CWB : 1;
    localparam int CYW   = (CHB > 0) ? CHB : 1;
    localparam int RGBW  = 3*COLOR_W;
    localparam int X_END = X0 + SCREEN_COLS*CHAR_WIDTH;
    localparam int Y_END = Y0 + SCREEN_ROWS*CHAR_HEIGHT;

    if ((CHAR_WIDTH < 1) || ((CHAR_WIDTH & (CHAR_WIDTH-1)) != 0) ||
        (CHAR_HEIGHT < 1) || ((CHAR_HEIGHT & (CHAR_HEIGHT-1)) != 0)) begin : g_bad_glyph
        $error("osd_overlay_attr: CHAR_WIDTH and CHAR_HEIGHT must be powers of 2");
    end

    typedef struct packed {
        logic            win;
        logic [CXW-1:0]  cx;
        logic [CYW-1:0]  cy;
        logic [7:0]      attr;
        logic [RGBW-1:0] rgb;
        logic            hb;
        logic            vb;
    } meta_t;

    typedef struct packed {
        logic            win;
        logic            pix;
        logic            bg_nz;
        logic [RGBW-1:0] fg;
        logic [RGBW-1:0] bg;
        logic [RGBW-1:0] rgb;
        logic            hb;
        logic            vb;
    } pix_t;

    localparam meta_t META_RST = '{hb: 1'b1, vb: 1'b1, default: '0};
    localparam pix_t  PIX_RST  = '{hb: 1'b1, vb: 1'b1, default: '0};

    // MSB-first bit replication of each RGB444 nibble up to COLOR_W
    function automatic logic [RGBW-1:0] expand(input logic [11:0] c);
        logic [RGBW-1:0] o;
        o = '0;
        for (int ch = 0; ch < 3; ch++) begin
            for (int b = 0; b < COLOR_W; b++) begin
                o[ch*COLOR_W + b] = c[ch*4 + 3 - ((COLOR_W - 1 - b) % 4)];
            end
        end
        return o;
    endfunction

    logic [9:0]      rx, ry;
    logic            in_win;
    logic [AW-1:0]   addr_nxt;
    meta_t           t0, s2_nxt;
    meta_t           s [4];
    pix_t            p5, p5_nxt;
    logic [RGBW-1:0] rgb_nxt;

    always_comb begin
        in_win = (int'(x) >= X0) && (int'(x) < X_END) && (int'(y) >= Y0) && (int'(y) < Y_END);
        rx = x - 10'(X0);
        ry = y - 10'(Y0);
        addr_nxt = '0;
        if (in_win) begin
            addr_nxt = AW'(32'(ry >> CHB) * 32'(SCREEN_COLS) + 32'(rx >> CWB));
        end
        t0      = META_RST;
        t0.win  = in_win;
        t0.cx   = CXW'(rx) & CXW'(CHAR_WIDTH - 1);
        t0.cy   = CYW'(ry) & CYW'(CHAR_HEIGHT - 1);
        t0.rgb  = rgb_in;
        t0.hb   = hblank;
        t0.vb   = vblank;
    end

    // Attribute byte joins the sideband when the text RAM output is consumed
    always_comb begin
        s2_nxt      = s[1];
        s2_nxt.attr = char_attr;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                s[i] <= META_RST;
            end
            addr_b    <= '0;
            font_addr <= '0;
        end else begin
            s[0]      <= t0;
            s[1]      <= s[0];
            s[2]      <= s2_nxt;
            s[3]      <= s[2];
            addr_b    <= addr_nxt;
            font_addr <= (FAW'(char_code) << CHB) | FAW'(s[1].cy);
        end
    end

    always_comb begin
        p5_nxt       = PIX_RST;
        p5_nxt.win   = s[3].win;
        p5_nxt.pix   = font_data[s[3].cx];
        p5_nxt.bg_nz = |s[3].attr[3:0];
        p5_nxt.fg    = expand(PALETTE[s[3].attr[7:4]]);
        p5_nxt.bg    = expand(PALETTE[s[3].attr[3:0]]);
        p5_nxt.rgb   = s[3].rgb;
        p5_nxt.hb    = s[3].hb;
        p5_nxt.vb    = s[3].vb;
    end

    always_comb begin
        rgb_nxt = p5.rgb;
        if (p5.hb || p5.vb) begin
            rgb_nxt = '0;
        end else if (osd_shown && p5.win) begin
            if (p5.pix) begin
                rgb_nxt = p5.fg;
            end else if (p5.bg_nz) begin
                rgb_nxt = p5.bg;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p5         <= PIX_RST;
            rgb_out    <= '0;
            hblank_out <= 1'b1;
            vblank_out <= 1'b1;
        end else begin
            p5         <= p5_nxt;
            rgb_out    <= rgb_nxt;
            hblank_out <= p5.hb;
            vblank_out <= p5.vb;
        end
    end

    osd_frame_timer #(
        .TIMEOUT_FRAMES (TIMEOUT_FRAMES)
    ) u_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .vblank      (vblank),
        .osd_trigger (osd_trigger),
        .osd_force   (osd_force),
        .osd_shown   (osd_shown)
    );

endmodule

// File: tb/tb_osd_overlay_attr.sv
// Scoreboarded bench for osd_overlay_attr: directed pixels and frame-timer sequences.
module tb_osd_overlay_attr;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        hblank, vblank, osd_trigger, osd_force;
    logic [9:0]  x, y;
    logic [23:0] rgb_in, rgb_out;
    logic [10:0] addr_b, font_addr;
    logic [7:0]  char_code, char_attr, font_data;
    logic        hblank_out, vblank_out, osd_shown;

    logic [7:0] tcode [2048];
    logic [7:0] tattr [2048];
    logic [7:0] from  [2048];

    always #5 clk = ~clk;

    osd_overlay_attr #(
        .CHAR_WIDTH(8), .CHAR_HEIGHT(8), .SCREEN_COLS(48), .SCREEN_ROWS(32),
        .X0(16), .Y0(8), .COLOR_W(8), .TIMEOUT_FRAMES(3)
    ) dut (
        .clk(clk), .reset_n(reset_n), .hblank(hblank), .vblank(vblank),
        .x(x), .y(y), .rgb_in(rgb_in), .osd_trigger(osd_trigger), .osd_force(osd_force),
        .addr_b(addr_b), .char_code(char_code), .char_attr(char_attr),
        .font_addr(font_addr), .font_data(font_data), .rgb_out(rgb_out),
        .hblank_out(hblank_out), .vblank_out(vblank_out), .osd_shown(osd_shown)
    );

    // Synchronous text RAM and font ROM, one clock read
    always @(posedge clk) begin
        char_code <= tcode[addr_b];
        char_attr <= tattr[addr_b];
        font_data <= from[font_addr];
    end

    typedef struct {
        int          due;
        int          kind;
        int          id;
        logic [23:0] rgb;
        logic [1:0]  blk;
        logic [10:0] val;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            0:       return "rgb_blank";
            1:       return "addr_b";
            2:       return "font_addr";
            default: return "osd_shown";
        endcase
    endfunction

    task automatic check(input exp_t e);
        logic [25:0] got, want;
        n_tests++;
        case (e.kind)
            0: begin got = {rgb_out, hblank_out, vblank_out}; want = {e.rgb, e.blk}; end
            1: begin got = 26'(addr_b);    want = 26'(e.val); end
            2: begin got = 26'(font_addr); want = 26'(e.val); end
            default: begin got = 26'(osd_shown); want = 26'(e.val[0]); end
        endcase
        if (e.due != cyc || got !== want) begin
            n_fail++;
            $display("FAIL %s #%0d cycle %0d (due %0d): got %h, want %h",
                     kname(e.kind), e.id, cyc, e.due, got, want);
        end
    endtask

    always @(negedge clk) begin
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].due <= cyc) begin
                check(sbq[i]);
                sbq.delete(i);
            end
        end
    end

    task automatic push(input int due, input int kind, input int id,
                        input logic [23:0] rgb, input logic [1:0] blk, input logic [10:0] val);
        exp_t e;
        e.due = due; e.kind = kind; e.id = id; e.rgb = rgb; e.blk = blk; e.val = val;
        sbq.push_back(e);
    endtask

    task automatic drive(input int xx, input int yy, input logic [23:0] rgb,
                         input logic hb, input logic vb, input logic trg);
        @(posedge clk);
        #1;
        x = 10'(xx); y = 10'(yy); rgb_in = rgb;
        hblank = hb; vblank = vb; osd_trigger = trg;
    endtask

    task automatic pix(input int xx, input int yy, input logic [23:0] rgb, input logic hb,
                       input logic [23:0] exp_rgb, input int exp_addr, input int exp_fa, input int id);
        drive(xx, yy, rgb, hb, 1'b0, 1'b0);
        push(cyc + 6, 0, id, exp_rgb, {hb, 1'b0}, '0);
        if (exp_addr >= 0) push(cyc + 1, 1, id, '0, '0, 11'(exp_addr));
        if (exp_fa >= 0)   push(cyc + 3, 2, id, '0, '0, 11'(exp_fa));
    endtask

    // Long hblank before vblank lets in-flight pixels composite before visibility changes
    task automatic vbl(input logic trg_at_edge);
        repeat (7) drive(0, 0, 24'h0, 1'b1, 1'b0, 1'b0);
        drive(0, 0, 24'h0, 1'b1, 1'b1, trg_at_edge);
        drive(0, 0, 24'h0, 1'b1, 1'b1, 1'b0);
        drive(0, 0, 24'h0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic chk_shown(input logic exp, input int id);
        push(cyc, 3, id, '0, '0, {10'd0, exp});
    endtask

    task automatic rst_chk(input int id);
        push(cyc, 0, id, 24'h0, 2'b11, '0);
        push(cyc, 1, id, '0, '0, '0);
        push(cyc, 2, id, '0, '0, '0);
        push(cyc, 3, id, '0, '0, '0);
    endtask

    task automatic mid_trigger();
        drive(200, 100, 24'h0, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        reset_n = 1'b0; hblank = 1'b1; vblank = 1'b1; x = '0; y = '0;
        rgb_in = '0; osd_trigger = 1'b0; osd_force = 1'b0;
        for (int i = 0; i < 2048; i++) begin
            tcode[i] = 8'h00; tattr[i] = 8'h00; from[i] = 8'h00;
        end
        tcode[1]    = 8'h41; tattr[1]    = 8'h40; from[11'h20A] = 8'h02;
        tcode[2]    = 8'h42; tattr[2]    = 8'h1C; from[11'h212] = 8'h80;
        tcode[48]   = 8'h07; tattr[48]   = 8'h2F; from[11'h03B] = 8'h01;
        tcode[1535] = 8'hFF; tattr[1535] = 8'h3E; from[11'h7FF] = 8'h80;

        repeat (3) @(posedge clk);
        #1;
        rst_chk(1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        vbl(1'b0); chk_shown(1'b0, 2);
        pix(25, 10, 24'h123456, 1'b0, 24'h123456, 1, 11'h20A, 3);
        mid_trigger(); chk_shown(1'b0, 4);

        vbl(1'b0); chk_shown(1'b1, 5);
        pix(25, 10, 24'h123456, 1'b0, 24'hAA0000, 1, 11'h20A, 6);
        pix(24, 10, 24'h654321, 1'b0, 24'h654321, 1, 11'h20A, 7);
        pix(15, 10, 24'hABCDEF, 1'b0, 24'hABCDEF, 0, -1, 8);
        pix(39, 10, 24'h000000, 1'b0, 24'h0000AA, 2, 11'h212, 9);
        pix(32, 10, 24'h111111, 1'b0, 24'hFF5555, 2, 11'h212, 10);
        pix(16, 19, 24'h222222, 1'b0, 24'h00AA00, 48, 11'h03B, 11);
        pix(399, 263, 24'h333333, 1'b0, 24'h00AAAA, 1535, 11'h7FF, 12);
        pix(400, 263, 24'h444444, 1'b0, 24'h444444, 0, -1, 13);
        pix(399, 264, 24'h555555, 1'b0, 24'h555555, 0, -1, 14);
        pix(25, 10, 24'h777777, 1'b1, 24'h000000, 1, -1, 15);
        vbl(1'b0); chk_shown(1'b1, 16);
        vbl(1'b0); chk_shown(1'b1, 17);
        vbl(1'b0); chk_shown(1'b0, 18);

        mid_trigger();
        vbl(1'b0); chk_shown(1'b1, 20);
        vbl(1'b0); chk_shown(1'b1, 21);
        mid_trigger();
        vbl(1'b0); chk_shown(1'b1, 22);
        vbl(1'b0); chk_shown(1'b1, 23);
        vbl(1'b0); chk_shown(1'b1, 24);
        vbl(1'b0); chk_shown(1'b0, 25);

        osd_force = 1'b1;
        drive(200, 100, 24'h0, 1'b1, 1'b0, 1'b0); chk_shown(1'b0, 30);
        vbl(1'b0); chk_shown(1'b1, 31);
        vbl(1'b0); chk_shown(1'b1, 32);
        osd_force = 1'b0;
        drive(200, 100, 24'h0, 1'b1, 1'b0, 1'b0);
        vbl(1'b0); chk_shown(1'b1, 33);
        vbl(1'b0); chk_shown(1'b1, 34);
        vbl(1'b0); chk_shown(1'b1, 35);
        vbl(1'b0); chk_shown(1'b0, 36);

        vbl(1'b1); chk_shown(1'b1, 40);
        vbl(1'b0); chk_shown(1'b1, 41);
        vbl(1'b0); chk_shown(1'b1, 42);
        vbl(1'b0); chk_shown(1'b1, 43);
        vbl(1'b0); chk_shown(1'b0, 44);

        mid_trigger();
        vbl(1'b0); chk_shown(1'b1, 50);
        drive(25, 10, 24'h999999, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b0;
        rst_chk(51);
        drive(25, 10, 24'h999999, 1'b0, 1'b0, 1'b0);
        drive(26, 10, 24'h999999, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        pix(25, 10, 24'h13579B, 1'b0, 24'h13579B, 1, 11'h20A, 52);
        vbl(1'b0); chk_shown(1'b0, 53);
        pix(25, 10, 24'h0F0F0F, 1'b0, 24'h0F0F0F, 1, 11'h20A, 54);
        vbl(1'b0); chk_shown(1'b0, 55);

        repeat (12) drive(0, 0, 24'h0, 1'b1, 1'b0, 1'b0);
        while (sbq.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s #%0d never checked (due %0d, now %0d)",
                     kname(sbq[0].kind), sbq[0].id, sbq[0].due, cyc);
            void'(sbq.pop_front());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
